// File: rtl/signal_phase_scheduler.sv
// Intersection phase sequencer: MAIN / TURN / PED greens separated by all-red CLEAR.
// Requests are latched and arbitrated round-robin; greens decode only from the state register.
module signal_phase_scheduler #(
   parameter int unsigned MIN_GREEN    = 8,
   parameter int unsigned TURN_CYCLES  = 4,
   parameter int unsigned PED_CYCLES   = 6,
   parameter int unsigned CLEAR_CYCLES = 2,
   parameter int unsigned TW           = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       pedestrian_button,
   input  logic       turn_sensor,
   output logic       pedestrian_green,
   output logic       up_green,
   output logic       down_green,
   output logic       turn_green,
   output logic [1:0] phase
);

   typedef enum logic [1:0] {
      StClear = 2'd0,
      StMain  = 2'd1,
      StTurn  = 2'd2,
      StPed   = 2'd3
   } state_e;

   localparam logic [TW-1:0] LdClear = TW'(CLEAR_CYCLES - 1);
   localparam logic [TW-1:0] LdMain  = TW'(MIN_GREEN - 1);
   localparam logic [TW-1:0] LdTurn  = TW'(TURN_CYCLES - 1);
   localparam logic [TW-1:0] LdPed   = TW'(PED_CYCLES - 1);
   localparam logic [TW-1:0] TOne    = TW'(1);
   localparam logic [TW-1:0] TZero   = '0;

   state_e          state_q, state_d;
   state_e          target_q, target_d;
   state_e          last_served_q, last_served_d;
   logic [TW-1:0]   t_q, t_d;
   logic            ped_req_q, ped_req_d;
   logic            turn_req_q, turn_req_d;

   // Timer reload value for the phase being entered from CLEAR.
   function automatic logic [TW-1:0] load_of(state_e s);
      case (s)
         StTurn:  load_of = LdTurn;
         StPed:   load_of = LdPed;
         StMain:  load_of = LdMain;
         default: load_of = LdClear;
      endcase
   endfunction

   // State, timer, request-latch and arbitration registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= StClear;
         target_q      <= StMain;
         last_served_q <= StPed;
         t_q           <= LdClear;
         ped_req_q     <= 1'b0;
         turn_req_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         target_q      <= target_d;
         last_served_q <= last_served_d;
         t_q           <= t_d;
         ped_req_q     <= ped_req_d;
         turn_req_q    <= turn_req_d;
      end
   end

   // Next-state: timer countdown, phase transitions and round-robin target selection.
   always_comb begin
      state_d       = state_q;
      target_d      = target_q;
      last_served_d = last_served_q;
      t_d           = (t_q == TZero) ? TZero : t_q - TOne;
      ped_req_d     = ped_req_q | pedestrian_button;
      turn_req_d    = turn_req_q | turn_sensor;

      unique case (state_q)
         StClear: begin
            if (t_q == TZero) begin
               state_d = target_q;
               t_d     = load_of(target_q);
            end
         end
         StMain: begin
            if ((t_q == TZero) && (ped_req_q || turn_req_q)) begin
               state_d = StClear;
               t_d     = LdClear;
               if (ped_req_q && turn_req_q) begin
                  target_d = (last_served_q == StPed) ? StTurn : StPed;
               end else if (ped_req_q) begin
                  target_d = StPed;
               end else begin
                  target_d = StTurn;
               end
            end
         end
         StTurn, StPed: begin
            if (t_q == TZero) begin
               last_served_d = state_q;
               state_d       = StClear;
               target_d      = StMain;
               t_d           = LdClear;
            end
         end
      endcase

      // A latch clears on entry to its phase and ignores its input for the whole phase,
      // including the exit edge, so a held button cannot re-request itself.
      if ((state_d == StPed) || (state_q == StPed)) begin
         ped_req_d = 1'b0;
      end
      if ((state_d == StTurn) || (state_q == StTurn)) begin
         turn_req_d = 1'b0;
      end
   end

   // Output decode from the state register only.
   always_comb begin
      pedestrian_green = 1'b0;
      up_green         = 1'b0;
      down_green       = 1'b0;
      turn_green       = 1'b0;
      phase            = state_q;
      unique case (state_q)
         StMain: begin
            up_green   = 1'b1;
            down_green = 1'b1;
         end
         StTurn: begin
            up_green   = 1'b1;
            turn_green = 1'b1;
         end
         StPed:   pedestrian_green = 1'b1;
         StClear: ;
      endcase
   end

endmodule

// File: tb/tb_signal_phase_scheduler.sv
// Directed and random bench for signal_phase_scheduler (default parameters plus an
// all-durations-equal-one instance for the boundary case).
module tb_signal_phase_scheduler;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       pb = 1'b0, ts = 1'b0;
   logic       pg, ug, dg, tg;
   logic [1:0] ph;
   logic       pb1 = 1'b0, ts1 = 1'b0;
   logic       pg1, ug1, dg1, tg1;
   logic [1:0] ph1;

   int n_checks = 0;
   int n_fail   = 0;

   signal_phase_scheduler dut (
      .clock             (clock),
      .reset             (reset),
      .pedestrian_button (pb),
      .turn_sensor       (ts),
      .pedestrian_green  (pg),
      .up_green          (ug),
      .down_green        (dg),
      .turn_green        (tg),
      .phase             (ph)
   );

   signal_phase_scheduler #(
      .MIN_GREEN    (1),
      .TURN_CYCLES  (1),
      .PED_CYCLES   (1),
      .CLEAR_CYCLES (1),
      .TW           (8)
   ) dut1 (
      .clock             (clock),
      .reset             (reset),
      .pedestrian_button (pb1),
      .turn_sensor       (ts1),
      .pedestrian_green  (pg1),
      .up_green          (ug1),
      .down_green        (dg1),
      .turn_green        (tg1),
      .phase             (ph1)
   );

   always #5 clock = ~clock;

   // Expected {ped, up, down, turn} for a phase code.
   function automatic logic [3:0] greens_of(logic [1:0] p);
      case (p)
         2'd1:    greens_of = 4'b0110;
         2'd2:    greens_of = 4'b0101;
         2'd3:    greens_of = 4'b1000;
         default: greens_of = 4'b0000;
      endcase
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Leaves reset released just after an edge, so the next posedge is E1.
   task automatic do_reset();
      reset = 1'b1;
      pb = 1'b0; ts = 1'b0; pb1 = 1'b0; ts1 = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      logic [1:0] exp;
      reset = 1'b1;
      pb = 1'b0; ts = 1'b0;
      step();
      step();
      n_checks++;
      if (ph !== 2'd0) begin
         n_fail++; $display("FAIL reset_phase got=%0d exp=0", ph);
      end
      n_checks++;
      if ({pg, ug, dg, tg} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_greens got=%b exp=0000", {pg, ug, dg, tg});
      end
      n_checks++;
      if (dut.t_q !== 8'd1) begin
         n_fail++; $display("FAIL reset_timer got=%0d exp=1", dut.t_q);
      end
      reset = 1'b0;
      for (int e = 1; e <= 25; e++) begin
         step();
         exp = (e < 2) ? 2'd0 : 2'd1;
         n_checks++;
         if (ph !== exp || {pg, ug, dg, tg} !== greens_of(exp)) begin
            n_fail++;
            $display("FAIL idle_E%0d got phase=%0d greens=%b exp phase=%0d greens=%b",
                     e, ph, {pg, ug, dg, tg}, exp, greens_of(exp));
         end
      end
   endtask

   task automatic test_ped();
      logic [1:0] exp;
      do_reset();
      for (int e = 1; e <= 31; e++) begin
         step();
         exp = (e < 2) ? 2'd0 : (e < 21) ? 2'd1 : (e < 23) ? 2'd0 : (e < 29) ? 2'd3 :
               (e < 31) ? 2'd0 : 2'd1;
         n_checks++;
         if (ph !== exp || {pg, ug, dg, tg} !== greens_of(exp)) begin
            n_fail++;
            $display("FAIL ped_E%0d got phase=%0d greens=%b exp phase=%0d greens=%b",
                     e, ph, {pg, ug, dg, tg}, exp, greens_of(exp));
         end
         if (exp == 2'd3) begin
            n_checks++;
            if (dut.ped_req_q !== 1'b0) begin
               n_fail++; $display("FAIL ped_req_in_ped_E%0d got=%b exp=0", e, dut.ped_req_q);
            end
         end
         pb = (e == 19);
      end
      pb = 1'b0;
   endtask

   task automatic test_turn_min_green();
      logic [1:0] exp;
      do_reset();
      for (int e = 1; e <= 18; e++) begin
         step();
         exp = (e < 2) ? 2'd0 : (e < 10) ? 2'd1 : (e < 12) ? 2'd0 : (e < 16) ? 2'd2 :
               (e < 18) ? 2'd0 : 2'd1;
         n_checks++;
         if (ph !== exp || {pg, ug, dg, tg} !== greens_of(exp)) begin
            n_fail++;
            $display("FAIL turn_E%0d got phase=%0d greens=%b exp phase=%0d greens=%b",
                     e, ph, {pg, ug, dg, tg}, exp, greens_of(exp));
         end
         ts = (e == 4);
      end
      ts = 1'b0;
   endtask

   task automatic test_round_robin();
      logic [1:0] exp;
      do_reset();
      for (int e = 1; e <= 52; e++) begin
         step();
         exp = (e < 2)  ? 2'd0 : (e < 10) ? 2'd1 : (e < 12) ? 2'd0 : (e < 16) ? 2'd2 :
               (e < 18) ? 2'd0 : (e < 26) ? 2'd1 : (e < 28) ? 2'd0 : (e < 34) ? 2'd3 :
               (e < 36) ? 2'd0 : (e < 44) ? 2'd1 : (e < 46) ? 2'd0 : (e < 50) ? 2'd2 :
               (e < 52) ? 2'd0 : 2'd1;
         n_checks++;
         if (ph !== exp) begin
            n_fail++; $display("FAIL rr_E%0d got phase=%0d exp=%0d", e, ph, exp);
         end
         pb = (e == 2) || (e == 37);
         ts = (e == 2) || (e == 37);
      end
      pb = 1'b0; ts = 1'b0;
   endtask

   task automatic test_ped_held();
      logic [1:0] exp;
      // Held through PED only: must not re-request.
      do_reset();
      for (int e = 1; e <= 45; e++) begin
         step();
         exp = (e < 2) ? 2'd0 : (e < 21) ? 2'd1 : (e < 23) ? 2'd0 : (e < 29) ? 2'd3 :
               (e < 31) ? 2'd0 : 2'd1;
         n_checks++;
         if (ph !== exp) begin
            n_fail++; $display("FAIL held_E%0d got phase=%0d exp=%0d", e, ph, exp);
         end
         pb = (e >= 19) && (e <= 28);
      end
      // Still high on the edge after PED ends (CLEAR): a fresh request.
      do_reset();
      for (int e = 1; e <= 46; e++) begin
         step();
         exp = (e < 2)  ? 2'd0 : (e < 21) ? 2'd1 : (e < 23) ? 2'd0 : (e < 29) ? 2'd3 :
               (e < 31) ? 2'd0 : (e < 39) ? 2'd1 : (e < 41) ? 2'd0 : 2'd3;
         n_checks++;
         if (ph !== exp) begin
            n_fail++; $display("FAIL repress_E%0d got phase=%0d exp=%0d", e, ph, exp);
         end
         pb = (e >= 19) && (e <= 29);
      end
      pb = 1'b0;
   endtask

   task automatic test_reset_mid_turn();
      logic [1:0] exp;
      do_reset();
      for (int e = 1; e <= 13; e++) begin
         step();
         exp = (e < 2) ? 2'd0 : (e < 10) ? 2'd1 : (e < 12) ? 2'd0 : 2'd2;
         n_checks++;
         if (ph !== exp) begin
            n_fail++; $display("FAIL midturn_E%0d got phase=%0d exp=%0d", e, ph, exp);
         end
         ts = (e == 4);
         pb = (e == 12);
      end
      pb = 1'b0;
      reset = 1'b1;
      step();
      n_checks++;
      if (ph !== 2'd0 || {pg, ug, dg, tg} !== 4'b0000) begin
         n_fail++;
         $display("FAIL midturn_reset got phase=%0d greens=%b exp phase=0 greens=0000",
                  ph, {pg, ug, dg, tg});
      end
      n_checks++;
      if (dut.ped_req_q !== 1'b0) begin
         n_fail++; $display("FAIL midturn_ped_req got=%b exp=0", dut.ped_req_q);
      end
      reset = 1'b0;
      for (int e = 1; e <= 16; e++) begin
         step();
         exp = (e < 2) ? 2'd0 : 2'd1;
         n_checks++;
         if (ph !== exp) begin
            n_fail++; $display("FAIL after_reset_E%0d got phase=%0d exp=%0d", e, ph, exp);
         end
      end
   endtask

   task automatic test_unit_durations();
      logic [1:0] exp_seq [6];
      exp_seq = '{2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd1};
      do_reset();
      ts1 = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         step();
         ts1 = 1'b0;
         n_checks++;
         if (ph1 !== exp_seq[e-1] || {pg1, ug1, dg1, tg1} !== greens_of(exp_seq[e-1])) begin
            n_fail++;
            $display("FAIL unit_E%0d got phase=%0d greens=%b exp phase=%0d",
                     e, ph1, {pg1, ug1, dg1, tg1}, exp_seq[e-1]);
         end
      end
   endtask

   task automatic test_random();
      logic [3:0] g, last_g;
      int         run;
      do_reset();
      last_g = 4'b0000;
      run    = 0;
      for (int i = 0; i < 3000; i++) begin
         pb = ($urandom_range(0, 15) == 0);
         ts = ($urandom_range(0, 11) == 0);
         step();
         g = {pg, ug, dg, tg};
         n_checks++;
         if ((pg && (ug || dg)) || (tg && dg)) begin
            n_fail++; $display("FAIL rand_conflict cyc=%0d got greens=%b", i, g);
         end
         n_checks++;
         if (g !== greens_of(ph)) begin
            n_fail++;
            $display("FAIL rand_decode cyc=%0d got greens=%b exp=%b", i, g, greens_of(ph));
         end
         if (g == 4'b0000) begin
            run++;
         end else begin
            if (last_g != 4'b0000 && g != last_g) begin
               n_checks++;
               if (run != 2) begin
                  n_fail++;
                  $display("FAIL rand_clearance cyc=%0d got=%0d exp=2", i, run);
               end
            end
            run    = 0;
            last_g = g;
         end
      end
      pb = 1'b0; ts = 1'b0;
   endtask

   initial begin
      test_reset();
      test_ped();
      test_turn_min_green();
      test_round_robin();
      test_ped_held();
      test_reset_mid_turn();
      test_unit_durations();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
